// File: rtl/ldst_pkg.sv
// Shared LSU definitions: widths, packet struct and issue FSM states used by
// the coalescer, this issue stage and the L1 request path.
package ldst_pkg;

   localparam int LANES      = 32;
   localparam int ADDR_W     = 32;
   localparam int WARP_W     = 2;
   localparam int REG_W      = 5;
   localparam int SEG_ALIGN  = 7;
   localparam int MAX_SEG    = 16;
   localparam int CNT_W      = 5;
   localparam int PKT_DEPTH  = 2;
   localparam int SEG_IDX_W  = $clog2(MAX_SEG);
   localparam int DATA_W     = LANES * 32;
   localparam int FIFO_CNT_W = $clog2(PKT_DEPTH) + 1;

   typedef struct packed {
      logic                             store;
      logic [WARP_W-1:0]                warp;
      logic [REG_W-1:0]                 regid;
      logic [CNT_W-1:0]                 segcnt;
      logic [MAX_SEG-1:0][ADDR_W-1:0]   addr;
      logic [MAX_SEG-1:0][LANES-1:0]    mask;
      logic [DATA_W-1:0]                sdata;
   } pkt_t;

   typedef enum logic {
      IDLE,
      ISSUE
   } issue_state_e;

   // Clamp an oversized segment count so the issue counter never walks past
   // the last populated segment slot.
   function automatic logic [CNT_W-1:0] sat_segcnt(input logic [CNT_W-1:0] c);
      return (c > CNT_W'(MAX_SEG)) ? CNT_W'(MAX_SEG) : c;
   endfunction

   // Segments are cache-line granular, so the offset bits are cleared.
   function automatic logic [ADDR_W-1:0] seg_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'((1 << SEG_ALIGN) - 1);
   endfunction

endpackage

// File: rtl/ldst_seg_issue_if.sv
// Bundle of the coalescer packet port and the L1 request port of the
// segment issue stage. The slave view belongs to the issue stage.
interface ldst_seg_issue_if;
   import ldst_pkg::*;

   logic                      pkt_valid_i;
   logic                      stall_o;
   logic                      pkt_store_i;
   logic [WARP_W-1:0]         pkt_warp_i;
   logic [REG_W-1:0]          pkt_reg_i;
   logic [CNT_W-1:0]          pkt_segcnt_i;
   logic [MAX_SEG*32-1:0]     pkt_addr_i;
   logic [MAX_SEG*32-1:0]     pkt_mask_i;
   logic [DATA_W-1:0]         pkt_sdata_i;

   logic                      l1_req_valid_o;
   logic                      l1_req_ready_i;
   logic                      l1_req_store_o;
   logic [WARP_W-1:0]         l1_req_warp_o;
   logic [REG_W-1:0]          l1_req_reg_o;
   logic [ADDR_W-1:0]         l1_req_addr_o;
   logic [LANES-1:0]          l1_req_mask_o;
   logic [DATA_W-1:0]         l1_req_data_o;
   logic                      l1_req_last_o;

   logic                      done_o;
   logic [WARP_W-1:0]         done_warp_o;
   logic                      busy_o;

   modport slave (
      input  pkt_valid_i, pkt_store_i, pkt_warp_i, pkt_reg_i, pkt_segcnt_i,
             pkt_addr_i, pkt_mask_i, pkt_sdata_i, l1_req_ready_i,
      output stall_o, l1_req_valid_o, l1_req_store_o, l1_req_warp_o,
             l1_req_reg_o, l1_req_addr_o, l1_req_mask_o, l1_req_data_o,
             l1_req_last_o, done_o, done_warp_o, busy_o
   );

   modport master (
      output pkt_valid_i, pkt_store_i, pkt_warp_i, pkt_reg_i, pkt_segcnt_i,
             pkt_addr_i, pkt_mask_i, pkt_sdata_i, l1_req_ready_i,
      input  stall_o, l1_req_valid_o, l1_req_store_o, l1_req_warp_o,
             l1_req_reg_o, l1_req_addr_o, l1_req_mask_o, l1_req_data_o,
             l1_req_last_o, done_o, done_warp_o, busy_o
   );

endinterface

// File: rtl/ldst_pkt_fifo.sv
// Generic synchronous FIFO with a combinational head read. Pushes while full
// and pops while empty are ignored. The occupancy counter is one bit wider
// than the pointers so full and empty are distinguishable.
module ldst_pkt_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem[rd_ptr_q];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push_ok && !pop_ok)      count_q <= count_q + CNT_ONE;
         else if (pop_ok && !push_ok) count_q <= count_q - CNT_ONE;
      end
   end

   // Storage array; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/ldst_seg_issue.sv
// Segment issue stage between the LSU coalescer and L1. Buffers coalesced
// warp packets and issues one 128B segment per cycle to L1, retiring a
// packet after its last segment handshake (or immediately if it has none).
module ldst_seg_issue
   import ldst_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   ldst_seg_issue_if.slave    bus
);

   pkt_t                   wr_pkt;
   pkt_t                   head;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic [FIFO_CNT_W-1:0]  count;

   issue_state_e           state_q, state_d;
   logic [SEG_IDX_W-1:0]   seg_idx_q, seg_idx_d;
   logic                   done_q;
   logic [WARP_W-1:0]      done_warp_q;
   logic                   req_valid;
   logic                   last_seg;

   assign push = bus.pkt_valid_i & ~full;

   // Pack the incoming packet, clamping the segment count at write time.
   always_comb begin
      wr_pkt        = '0;
      wr_pkt.store  = bus.pkt_store_i;
      wr_pkt.warp   = bus.pkt_warp_i;
      wr_pkt.regid  = bus.pkt_reg_i;
      wr_pkt.segcnt = sat_segcnt(bus.pkt_segcnt_i);
      wr_pkt.addr   = bus.pkt_addr_i;
      wr_pkt.mask   = bus.pkt_mask_i;
      wr_pkt.sdata  = bus.pkt_sdata_i;
   end

   ldst_pkt_fifo #(
      .WIDTH ($bits(pkt_t)),
      .DEPTH (PKT_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_pkt),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign last_seg = (CNT_W'(seg_idx_q) == head.segcnt - CNT_W'(1));

   // Issue FSM: walk the head packet's segments, pop on the last handshake,
   // and stay in ISSUE while more packets remain so there is no bubble.
   always_comb begin
      state_d   = state_q;
      seg_idx_d = seg_idx_q;
      pop       = 1'b0;
      req_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (push || !empty) state_d = ISSUE;
         end
         ISSUE: begin
            if (head.segcnt == '0) begin
               pop = 1'b1;
            end else begin
               req_valid = 1'b1;
               if (bus.l1_req_ready_i) begin
                  if (last_seg) begin
                     pop       = 1'b1;
                     seg_idx_d = '0;
                  end else begin
                     seg_idx_d = seg_idx_q + SEG_IDX_W'(1);
                  end
               end
            end
            if (pop && count == FIFO_CNT_W'(1) && !push) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request mux from the head entry; fields read as zero when not valid.
   always_comb begin
      bus.l1_req_valid_o = req_valid;
      bus.l1_req_store_o = 1'b0;
      bus.l1_req_warp_o  = '0;
      bus.l1_req_reg_o   = '0;
      bus.l1_req_addr_o  = '0;
      bus.l1_req_mask_o  = '0;
      bus.l1_req_data_o  = '0;
      bus.l1_req_last_o  = 1'b0;
      if (req_valid) begin
         bus.l1_req_store_o = head.store;
         bus.l1_req_warp_o  = head.warp;
         bus.l1_req_reg_o   = head.regid;
         bus.l1_req_addr_o  = seg_align(head.addr[seg_idx_q]);
         bus.l1_req_mask_o  = head.mask[seg_idx_q];
         bus.l1_req_data_o  = head.sdata;
         bus.l1_req_last_o  = last_seg;
      end
   end

   // State, segment index and the registered retirement pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         seg_idx_q   <= '0;
         done_q      <= 1'b0;
         done_warp_q <= '0;
      end else begin
         state_q     <= state_d;
         seg_idx_q   <= seg_idx_d;
         done_q      <= pop;
         done_warp_q <= pop ? head.warp : '0;
      end
   end

   assign bus.stall_o     = full;
   assign bus.done_o      = done_q;
   assign bus.done_warp_o = done_warp_q;
   assign bus.busy_o      = ~empty | (state_q == ISSUE);

endmodule
